abro_input_conditioner: RTL

Front-end stage that sits directly upstream of the ABRO state machine. Takes three raw, asynchronous, bouncy button inputs (A, B, reset request), synchronizes each into the `clk` domain and debounces it. It then delivers clean single-cycle rising-edge pulses `A`/`B` and a reset-request pulse that the ABRO FSM consumes. Debounced levels are also exported for status display.

---
 rtl/abro_input_conditioner.sv | 83 ++++++++
 1 files changed

// File: rtl/abro_input_conditioner.sv
// abro_input_conditioner: synchronizes and debounces the raw A, B and
// reset-request buttons, then emits one-cycle rising-edge pulses for the
// downstream ABRO FSM. A reset-request edge masks any A/B edge that lands
// on the same clock edge.
module abro_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  input  logic r_raw,
  output logic A,
  output logic B,
  output logic r_pulse,
  output logic a_level,
  output logic b_level
);

  localparam int unsigned NCH  = 3;
  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_R = 2;

  // Last count value before a new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] rise_c;

  assign raw = {r_raw, b_raw, a_raw};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             st;
    logic [CNT_W-1:0] cnt;
    logic             accept_c;

    // Two-flop synchronizer followed by the hold-time debounce counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        st  <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 == st) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          st  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    // A new level is accepted this edge; only 0->1 acceptances make an edge.
    assign accept_c  = (s2 != st) && (cnt == CNT_LAST);
    assign rise_c[g] = accept_c & s2;
  end

  // Registered edge pulses; a reset-request edge suppresses A/B on that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A       <= 1'b0;
      B       <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= rise_c[CH_R];
      A       <= rise_c[CH_A] & ~rise_c[CH_R];
      B       <= rise_c[CH_B] & ~rise_c[CH_R];
    end
  end

  assign a_level = g_ch[CH_A].st;
  assign b_level = g_ch[CH_B].st;

endmodule
